// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 keyboard receiver.
//   PS2_BREAK      - scan-code prefix that marks a key release
//   PS2_FRAME_BITS - bits following the start bit (8 data, parity, stop)
//   ps2_state_e    - receiver FSM state
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam int         PS2_FRAME_BITS = 10;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } ps2_state_e;

endpackage

// File: rtl/ps2_fifo.sv
// ps2_fifo: synchronous FIFO, WIDTH x DEPTH (DEPTH a power of two, >= 2).
//   clk, rst  - clock, async active-low reset
//   push, din - write request and data; ignored while full unless popping
//   pop       - read request; ignored while empty
//   full      - no free entry
//   empty     - no valid entry
//   head      - oldest entry (zero after reset)
// Pointers carry one extra MSB so full and empty are told apart by it.
module ps2_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW:0]                 wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver with scan-code FIFO and key-press count.
//   clk, rst          - system clock, async active-low reset
//   ps2_clk, ps2_data - raw keyboard pins (asynchronous, idle high)
//   out_ready         - consumer takes the FIFO head
//   out_valid         - FIFO non-empty
//   out_data          - FIFO head scan code
//   key_cnt           - make codes seen (wraps at 256)
//   overflow          - sticky: valid frame arrived while FIFO full
//   frame_err         - sticky: bad stop, bad parity (if checked), or timeout
// Build option: define PS2_PARITY_CHK_EN to reject frames failing odd parity.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [7:0] key_cnt,
  output logic       overflow,
  output logic       frame_err
);

`ifdef PS2_PARITY_CHK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          fall, bit_in;
  ps2_state_e    state;
  logic [3:0]    bitcnt;
  logic [8:0]    sh;          // data bits 0-7, parity in bit 8
  logic [TW-1:0] idle_cnt;
  logic          push, pop, full, empty, brk, frame_ok;
  logic [7:0]    push_data;

  // Two-stage synchronisers; clk_sync[2] is the edge-detect history tap.
  // fall is registered, so it rises 3 cycles after the pin edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      fall     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      fall     <= clk_sync[2] & ~clk_sync[1];
    end
  end

  assign bit_in = dat_sync[1];
  // Evaluated on the stop-bit fall: bit_in is the stop bit itself.
  assign frame_ok = bit_in & ((^sh) | ~PAR_CHK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      bitcnt    <= '0;
      sh        <= '0;
      idle_cnt  <= '0;
      push      <= 1'b0;
      push_data <= '0;
      frame_err <= 1'b0;
    end else begin
      push <= 1'b0;
      case (state)
        ST_IDLE: begin
          idle_cnt <= '0;
          if (fall && !bit_in) begin
            bitcnt <= '0;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (fall) begin
            idle_cnt <= '0;
            if (bitcnt == 4'(PS2_FRAME_BITS - 1)) begin
              state <= ST_IDLE;
              if (frame_ok) begin
                push      <= 1'b1;
                push_data <= sh[7:0];
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              sh     <= {bit_in, sh[8:1]};
              bitcnt <= bitcnt + 4'd1;
            end
          end else if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
            state     <= ST_IDLE;
            frame_err <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pop       = out_valid & out_ready;
  assign out_valid = ~empty;

  // Counting and break tracking run even when the FIFO drops the byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_cnt  <= '0;
      brk      <= 1'b0;
      overflow <= 1'b0;
    end else if (push) begin
      if (push_data == PS2_BREAK) brk <= 1'b1;
      else if (brk)               brk <= 1'b0;
      else                        key_cnt <= key_cnt + 8'd1;
      if (full && !pop) overflow <= 1'b1;
    end
  end

  ps2_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .full  (full),
    .empty (empty),
    .head  (out_data)
  );

endmodule
